// File: rtl/pcie_rx_tlp_gen.sv
// Host-side TLP source: emits one 32-bit-addressed MWr or MRd TLP per start
// request on the AXI4-Stream receive path into the user PCIe core.
module pcie_rx_tlp_gen #(
   parameter logic [15:0] REQUESTER_ID = 16'h0100,
   parameter logic [6:0]  BAR_HIT      = 7'h01,
   parameter int unsigned GAP_CYCLES   = 1
) (
   input  logic        sys_clk_p,
   input  logic        sys_reset,
   input  logic        i_start,
   input  logic        i_is_read,
   input  logic [31:0] i_addr,
   input  logic [9:0]  i_len,
   input  logic [7:0]  i_tag,
   input  logic [31:0] i_data_seed,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_tlp_count,
   output logic [31:0] m_axis_rx_tdata,
   output logic [3:0]  m_axis_rx_tkeep,
   output logic        m_axis_rx_tlast,
   output logic        m_axis_rx_tvalid,
   input  logic        m_axis_rx_tready,
   output logic [21:0] m_axis_rx_tuser,
   input  logic        rx_np_ok,
   output logic [2:0]  fsm_state
);

   // Stream handshake: a beat transfers on a rising edge where tvalid and
   // tready are both high; while tvalid is high and tready low, tdata, tlast
   // and tuser hold, and tvalid stays high until the TLP's last beat.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_NP = 3'd1,
      S_HDR0    = 3'd2,
      S_HDR1    = 3'd3,
      S_HDR2    = 3'd4,
      S_DATA    = 3'd5,
      S_GAP     = 3'd6
   } state_t;

   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 1) : 8'd0;

   state_t      state;
   logic        is_read_q;
   logic [31:0] addr_q;
   logic [9:0]  len_q;
   logic [7:0]  tag_q;
   logic [31:0] seed_q;
   logic [10:0] beat_cnt;
   logic [7:0]  gap_cnt;
   logic [10:0] eff_len;
   logic        beat;

   assign eff_len         = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};
   assign beat            = m_axis_rx_tvalid && m_axis_rx_tready;
   assign m_axis_rx_tkeep = 4'hF;
   assign m_axis_rx_tuser = {13'h0, (m_axis_rx_tvalid ? BAR_HIT : 7'h00), 2'b00};
   assign fsm_state       = state;

   function automatic logic [31:0] dw0(input logic rd, input logic [9:0] len);
      return {1'b0, (rd ? 2'b00 : 2'b10), 5'b00000, 1'b0, 3'b000, 4'h0,
              1'b0, 1'b0, 2'b00, 2'b00, len};
   endfunction

   always_ff @(posedge sys_clk_p or posedge sys_reset) begin
      if (sys_reset) begin
         state            <= S_IDLE;
         m_axis_rx_tvalid <= 1'b0;
         m_axis_rx_tlast  <= 1'b0;
         m_axis_rx_tdata  <= 32'h0;
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
         o_tlp_count      <= 16'h0;
         is_read_q        <= 1'b0;
         addr_q           <= 32'h0;
         len_q            <= 10'h0;
         tag_q            <= 8'h0;
         seed_q           <= 32'h0;
         beat_cnt         <= 11'h0;
         gap_cnt          <= 8'h0;
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  is_read_q <= i_is_read;
                  addr_q    <= i_addr & 32'hFFFF_FFFC;
                  len_q     <= i_len;
                  tag_q     <= i_tag;
                  seed_q    <= i_data_seed;
                  o_busy    <= 1'b1;
                  // Posted writes never wait; reads need the sink's NP credit.
                  if (!i_is_read || rx_np_ok) begin
                     m_axis_rx_tdata  <= dw0(i_is_read, i_len);
                     m_axis_rx_tvalid <= 1'b1;
                     state            <= S_HDR0;
                  end else begin
                     state <= S_WAIT_NP;
                  end
               end
            end
            S_WAIT_NP: begin
               if (rx_np_ok) begin
                  m_axis_rx_tdata  <= dw0(is_read_q, len_q);
                  m_axis_rx_tvalid <= 1'b1;
                  state            <= S_HDR0;
               end
            end
            S_HDR0: begin
               if (beat) begin
                  m_axis_rx_tdata <= {REQUESTER_ID, tag_q,
                                      ((eff_len == 11'd1) ? 4'h0 : 4'hF), 4'hF};
                  state           <= S_HDR1;
               end
            end
            S_HDR1: begin
               if (beat) begin
                  m_axis_rx_tdata <= addr_q;
                  m_axis_rx_tlast <= is_read_q;
                  state           <= S_HDR2;
               end
            end
            S_HDR2: begin
               if (beat) begin
                  if (is_read_q) begin
                     m_axis_rx_tvalid <= 1'b0;
                     m_axis_rx_tlast  <= 1'b0;
                     m_axis_rx_tdata  <= 32'h0;
                     o_done           <= 1'b1;
                     o_tlp_count      <= o_tlp_count + 16'd1;
                     gap_cnt          <= GAP_LOAD;
                     state            <= S_GAP;
                  end else begin
                     m_axis_rx_tdata <= seed_q;
                     m_axis_rx_tlast <= (eff_len == 11'd1);
                     beat_cnt        <= 11'd1;
                     state           <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (beat) begin
                  if (m_axis_rx_tlast) begin
                     m_axis_rx_tvalid <= 1'b0;
                     m_axis_rx_tlast  <= 1'b0;
                     m_axis_rx_tdata  <= 32'h0;
                     o_done           <= 1'b1;
                     o_tlp_count      <= o_tlp_count + 16'd1;
                     gap_cnt          <= GAP_LOAD;
                     state            <= S_GAP;
                  end else begin
                     // beat_cnt is the index of the word being loaded now.
                     m_axis_rx_tdata <= m_axis_rx_tdata + 32'd1;
                     m_axis_rx_tlast <= (beat_cnt == eff_len - 11'd1);
                     beat_cnt        <= beat_cnt + 11'd1;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == 8'd0) begin
                  o_busy <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcie_rx_tlp_gen.sv
// Self-checking bench for pcie_rx_tlp_gen: scenario tasks compare captured
// stream beats against a TLP model built from the header/payload rules.
module tb_pcie_rx_tlp_gen;

   localparam int TB_GAP = 3;
   localparam int G_LEN  = (TB_GAP == 0) ? 1 : TB_GAP;

   logic        sys_clk_p = 1'b0;
   logic        sys_reset;
   logic        i_start;
   logic        i_is_read;
   logic [31:0] i_addr;
   logic [9:0]  i_len;
   logic [7:0]  i_tag;
   logic [31:0] i_data_seed;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_tlp_count;
   logic [31:0] m_axis_rx_tdata;
   logic [3:0]  m_axis_rx_tkeep;
   logic        m_axis_rx_tlast;
   logic        m_axis_rx_tvalid;
   logic        m_axis_rx_tready;
   logic [21:0] m_axis_rx_tuser;
   logic        rx_np_ok;
   logic [2:0]  fsm_state;

   pcie_rx_tlp_gen #(.GAP_CYCLES(TB_GAP)) dut (
      .sys_clk_p(sys_clk_p), .sys_reset(sys_reset), .i_start(i_start),
      .i_is_read(i_is_read), .i_addr(i_addr), .i_len(i_len), .i_tag(i_tag),
      .i_data_seed(i_data_seed), .o_busy(o_busy), .o_done(o_done),
      .o_tlp_count(o_tlp_count), .m_axis_rx_tdata(m_axis_rx_tdata),
      .m_axis_rx_tkeep(m_axis_rx_tkeep), .m_axis_rx_tlast(m_axis_rx_tlast),
      .m_axis_rx_tvalid(m_axis_rx_tvalid), .m_axis_rx_tready(m_axis_rx_tready),
      .m_axis_rx_tuser(m_axis_rx_tuser), .rx_np_ok(rx_np_ok), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 sys_clk_p = ~sys_clk_p;

   int cyc = 0;
   always @(posedge sys_clk_p) cyc++;

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];
   logic        exp_last_q[$];
   logic [31:0] got_data[$];
   logic        got_last[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          stall_err = 0;
   int          user_err = 0;
   int          last_hs_cyc = 0;
   logic [15:0] exp_count = 16'h0;
   bit          bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   // Monitor: records accepted beats and flags stream-rule breaks.
   logic        prev_stall = 1'b0;
   logic        in_tlp = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;
   logic [21:0] prev_user;
   always @(negedge sys_clk_p) begin
      if (sys_reset) begin
         prev_stall = 1'b0;
         in_tlp     = 1'b0;
      end else begin
         if (prev_stall && (m_axis_rx_tvalid !== 1'b1 || m_axis_rx_tdata !== prev_data ||
                            m_axis_rx_tlast !== prev_last || m_axis_rx_tuser !== prev_user))
            stall_err++;
         if (in_tlp && m_axis_rx_tvalid !== 1'b1) stall_err++;
         if (m_axis_rx_tvalid === 1'b1 && m_axis_rx_tuser !== 22'h4) user_err++;
         if (m_axis_rx_tvalid !== 1'b1 && m_axis_rx_tuser !== 22'h0) user_err++;
         if (m_axis_rx_tvalid === 1'b1 && m_axis_rx_tready === 1'b1) begin
            got_data.push_back(m_axis_rx_tdata);
            got_last.push_back(m_axis_rx_tlast);
            in_tlp = !m_axis_rx_tlast;
            if (m_axis_rx_tlast === 1'b1) last_hs_cyc = cyc;
         end
         prev_stall = m_axis_rx_tvalid && !m_axis_rx_tready;
         prev_data  = m_axis_rx_tdata;
         prev_last  = m_axis_rx_tlast;
         prev_user  = m_axis_rx_tuser;
      end
   end

   // ---------------- reference model ----------------
   task automatic model_tlp(input bit rd, input logic [31:0] addr, input logic [9:0] len,
                            input logic [7:0] tag, input logic [31:0] seed);
      int n;
      n = (len == 10'd0) ? 1024 : int'(len);
      exp_q.push_back((rd ? 32'h0000_0000 : 32'h4000_0000) | {22'h0, len});
      exp_last_q.push_back(1'b0);
      exp_q.push_back({16'h0100, tag, ((n == 1) ? 4'h0 : 4'hF), 4'hF});
      exp_last_q.push_back(1'b0);
      exp_q.push_back(addr & ~32'h3);
      exp_last_q.push_back(rd);
      if (!rd) begin
         for (int k = 0; k < n; k++) begin
            exp_q.push_back(seed + 32'(k));
            exp_last_q.push_back(k == n - 1);
         end
      end
   endtask

   task automatic clear_q();
      exp_q.delete();
      exp_last_q.delete();
      got_data.delete();
      got_last.delete();
   endtask

   // ---------------- drivers ----------------
   task automatic start_tlp(input bit rd, input logic [31:0] addr, input logic [9:0] len,
                            input logic [7:0] tag, input logic [31:0] seed);
      int w;
      w = 0;
      @(negedge sys_clk_p);
      while (o_busy !== 1'b0 && w < 2000) begin
         @(negedge sys_clk_p);
         w++;
      end
      if (w >= 2000) begin
         n_cmp++; n_err++;
         $display("FAIL start_idle_wait busy=%b want 0 within 2000 cycles", o_busy);
      end
      @(posedge sys_clk_p); #1;
      i_start = 1'b1; i_is_read = rd; i_addr = addr; i_len = len; i_tag = tag; i_data_seed = seed;
      @(posedge sys_clk_p); #1;
      i_start = 1'b0;
      // Scramble the request inputs; the DUT must use its captured copy.
      i_is_read = 1'($urandom_range(0, 1)); i_addr = $urandom; i_len = 10'($urandom);
      i_tag = 8'($urandom); i_data_seed = $urandom;
   endtask

   // mode 0: leave tready; 1: 1,0,0,1 pattern; 2: random tready and rx_np_ok
   task automatic run_until_done(input int mode, input int budget, output bit ok, output int done_cyc);
      ok = 1'b0;
      done_cyc = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge sys_clk_p);
         if (o_done === 1'b1) begin
            ok = 1'b1;
            done_cyc = cyc;
            break;
         end
         @(posedge sys_clk_p); #1;
         if (mode == 1) m_axis_rx_tready = bp_pat[c % 4];
         if (mode == 2) begin
            m_axis_rx_tready = 1'($urandom_range(0, 1));
            rx_np_ok = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      sys_reset = 1'b1;
      repeat (3) @(posedge sys_clk_p);
      @(negedge sys_clk_p);
      n_cmp++; if (m_axis_rx_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", m_axis_rx_tvalid); end
      n_cmp++; if (m_axis_rx_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", m_axis_rx_tlast); end
      n_cmp++; if (m_axis_rx_tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata got %h want 0", m_axis_rx_tdata); end
      n_cmp++; if (m_axis_rx_tkeep !== 4'hF) begin n_err++; $display("FAIL reset_tkeep got %h want f", m_axis_rx_tkeep); end
      n_cmp++; if (m_axis_rx_tuser !== 22'h0) begin n_err++; $display("FAIL reset_tuser got %h want 0", m_axis_rx_tuser); end
      n_cmp++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done got %b%b want 00", o_busy, o_done); end
      n_cmp++; if (o_tlp_count !== 16'h0) begin n_err++; $display("FAIL reset_count got %0d want 0", o_tlp_count); end
      sys_reset = 1'b0;
      exp_count = 16'h0;
   endtask

   task automatic test_mwr_basic();
      bit ok; int dc; int bh; int dn;
      clear_q();
      m_axis_rx_tready = 1'b1; rx_np_ok = 1'b1;
      model_tlp(1'b0, 32'h1000, 10'd4, 8'h05, 32'hA0);
      start_tlp(1'b0, 32'h1000, 10'd4, 8'h05, 32'hA0);
      @(negedge sys_clk_p);
      n_cmp++;
      if (m_axis_rx_tvalid !== 1'b1 || m_axis_rx_tdata !== 32'h4000_0004) begin
         n_err++; $display("FAIL mwr_latency got v=%b d=%h want v=1 d=40000004", m_axis_rx_tvalid, m_axis_rx_tdata);
      end
      run_until_done(0, 50, ok, dc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL mwr_done_timeout got none want o_done"); end
      n_cmp++; if (dc != last_hs_cyc + 1) begin n_err++; $display("FAIL mwr_done_cycle got %0d want %0d", dc, last_hs_cyc + 1); end
      n_cmp++;
      if (got_data.size() != exp_q.size()) begin n_err++; $display("FAIL mwr_nbeats got %0d want %0d", got_data.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
         n_cmp++;
         if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i]) begin
            n_err++; $display("FAIL mwr_beat[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], exp_last_q[i]);
         end
      end
      exp_count++;
      n_cmp++; if (o_tlp_count !== exp_count) begin n_err++; $display("FAIL mwr_count got %0d want %0d", o_tlp_count, exp_count); end
      bh = 0; dn = 0;
      while (o_busy === 1'b1 && bh < 20) begin
         bh++;
         if (o_done === 1'b1) dn++;
         @(negedge sys_clk_p);
      end
      n_cmp++; if (bh != G_LEN) begin n_err++; $display("FAIL mwr_gap_busy got %0d want %0d", bh, G_LEN); end
      n_cmp++; if (dn != 1) begin n_err++; $display("FAIL mwr_done_width got %0d want 1", dn); end
   endtask

   task automatic test_mrd_np();
      bit ok; int dc; int w;
      clear_q();
      m_axis_rx_tready = 1'b1; rx_np_ok = 1'b0;
      model_tlp(1'b1, 32'h2007, 10'd1, 8'h07, 32'h0);
      start_tlp(1'b1, 32'h2007, 10'd1, 8'h07, $urandom);
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clk_p);
         n_cmp++;
         if (m_axis_rx_tvalid !== 1'b0 || o_busy !== 1'b1) begin
            n_err++; $display("FAIL mrd_np_wait cycle %0d got v=%b busy=%b want v=0 busy=1", i, m_axis_rx_tvalid, o_busy);
         end
      end
      @(posedge sys_clk_p); #1;
      rx_np_ok = 1'b1;
      w = 0;
      @(negedge sys_clk_p);
      while (m_axis_rx_tvalid !== 1'b1 && w < 10) begin
         @(negedge sys_clk_p);
         w++;
      end
      rx_np_ok = 1'b0;  // dropping credit mid-TLP must not matter
      run_until_done(0, 50, ok, dc);
      rx_np_ok = 1'b1;
      n_cmp++; if (!ok) begin n_err++; $display("FAIL mrd_done_timeout got none want o_done"); end
      n_cmp++;
      if (got_data.size() != exp_q.size()) begin n_err++; $display("FAIL mrd_nbeats got %0d want %0d", got_data.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
         n_cmp++;
         if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i]) begin
            n_err++; $display("FAIL mrd_beat[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], exp_last_q[i]);
         end
      end
      exp_count++;
      n_cmp++; if (o_tlp_count !== exp_count) begin n_err++; $display("FAIL mrd_count got %0d want %0d", o_tlp_count, exp_count); end
   endtask

   task automatic test_backpressure();
      bit ok; int dc;
      clear_q();
      m_axis_rx_tready = 1'b1; rx_np_ok = 1'b1;
      model_tlp(1'b0, 32'h1000, 10'd4, 8'h05, 32'hA0);
      start_tlp(1'b0, 32'h1000, 10'd4, 8'h05, 32'hA0);
      run_until_done(1, 100, ok, dc);
      m_axis_rx_tready = 1'b1;
      n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_done_timeout got none want o_done"); end
      n_cmp++;
      if (got_data.size() != exp_q.size()) begin n_err++; $display("FAIL bp_nbeats got %0d want %0d", got_data.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
         n_cmp++;
         if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i]) begin
            n_err++; $display("FAIL bp_beat[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], exp_last_q[i]);
         end
      end
      n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL bp_stall_hold got %0d violations want 0", stall_err); end
      exp_count++;
      n_cmp++; if (o_tlp_count !== exp_count) begin n_err++; $display("FAIL bp_count got %0d want %0d", o_tlp_count, exp_count); end
   endtask

   task automatic test_len0_wrap();
      bit ok; int dc;
      clear_q();
      m_axis_rx_tready = 1'b1; rx_np_ok = 1'b1;
      model_tlp(1'b0, 32'h0000_8000, 10'd0, 8'h3C, 32'hFFFF_FFFE);
      start_tlp(1'b0, 32'h0000_8000, 10'd0, 8'h3C, 32'hFFFF_FFFE);
      run_until_done(0, 1200, ok, dc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL len0_done_timeout got none want o_done"); end
      n_cmp++;
      if (got_data.size() != 1027) begin n_err++; $display("FAIL len0_nbeats got %0d want 1027", got_data.size()); end
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
         n_cmp++;
         if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i]) begin
            n_err++; $display("FAIL len0_beat[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], exp_last_q[i]);
         end
      end
      exp_count++;
      n_cmp++; if (o_tlp_count !== exp_count) begin n_err++; $display("FAIL len0_count got %0d want %0d", o_tlp_count, exp_count); end
   endtask

   task automatic test_random();
      bit ok; int dc; bit rd; logic [31:0] addr; logic [9:0] len; logic [7:0] tag; logic [31:0] seed;
      for (int t = 0; t < 8; t++) begin
         clear_q();
         rd = 1'($urandom_range(0, 1)); addr = $urandom; len = 10'($urandom_range(1, 12));
         tag = 8'($urandom); seed = $urandom;
         rx_np_ok = 1'($urandom_range(0, 1)); m_axis_rx_tready = 1'($urandom_range(0, 1));
         model_tlp(rd, addr, len, tag, seed);
         start_tlp(rd, addr, len, tag, seed);
         run_until_done(2, 400, ok, dc);
         m_axis_rx_tready = 1'b1; rx_np_ok = 1'b1;
         n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd%0d_done_timeout got none want o_done", t); end
         n_cmp++;
         if (got_data.size() != exp_q.size()) begin n_err++; $display("FAIL rnd%0d_nbeats got %0d want %0d", t, got_data.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i]) begin
               n_err++; $display("FAIL rnd%0d_beat[%0d] got %h/%b want %h/%b", t, i, got_data[i], got_last[i], exp_q[i], exp_last_q[i]);
            end
         end
         exp_count++;
         n_cmp++; if (o_tlp_count !== exp_count) begin n_err++; $display("FAIL rnd%0d_count got %0d want %0d", t, o_tlp_count, exp_count); end
      end
      n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL rnd_stall_hold got %0d violations want 0", stall_err); end
      n_cmp++; if (user_err != 0) begin n_err++; $display("FAIL rnd_tuser got %0d violations want 0", user_err); end
   endtask

   task automatic test_busy_start();
      bit ok; int dc; int w; int extra;
      clear_q();
      m_axis_rx_tready = 1'b1; rx_np_ok = 1'b1;
      model_tlp(1'b0, 32'h0000_4444, 10'd8, 8'h11, 32'h1234_0000);
      start_tlp(1'b0, 32'h0000_4444, 10'd8, 8'h11, 32'h1234_0000);
      w = 0;
      while (got_data.size() < 5 && w < 50) begin
         @(negedge sys_clk_p);
         w++;
      end
      @(posedge sys_clk_p); #1;
      i_start = 1'b1; i_is_read = 1'b1; i_len = 10'd2; i_addr = 32'hDEAD_0000;
      @(posedge sys_clk_p); #1;
      i_start = 1'b0;
      run_until_done(0, 50, ok, dc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL busy_done_timeout got none want o_done"); end
      extra = 0;
      repeat (G_LEN + 4) begin
         @(negedge sys_clk_p);
         if (m_axis_rx_tvalid === 1'b1) extra++;
      end
      n_cmp++; if (extra != 0) begin n_err++; $display("FAIL busy_extra_tlp got %0d valid cycles want 0", extra); end
      n_cmp++;
      if (got_data.size() != exp_q.size()) begin n_err++; $display("FAIL busy_nbeats got %0d want %0d", got_data.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
         n_cmp++;
         if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i]) begin
            n_err++; $display("FAIL busy_beat[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], exp_last_q[i]);
         end
      end
      exp_count++;
      n_cmp++; if (o_tlp_count !== exp_count) begin n_err++; $display("FAIL busy_count got %0d want %0d", o_tlp_count, exp_count); end
   endtask

   task automatic test_reset_mid();
      bit ok; int dc; int w;
      clear_q();
      m_axis_rx_tready = 1'b1; rx_np_ok = 1'b1;
      start_tlp(1'b0, 32'h0000_9000, 10'd20, 8'h22, 32'h5555_0000);
      w = 0;
      while (got_data.size() < 8 && w < 50) begin
         @(negedge sys_clk_p);
         w++;
      end
      #2;
      sys_reset = 1'b1;
      #1;
      n_cmp++; if (m_axis_rx_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got %b want 0", m_axis_rx_tvalid); end
      n_cmp++; if (o_tlp_count !== 16'h0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", o_tlp_count); end
      n_cmp++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_done got %b%b want 00", o_busy, o_done); end
      exp_count = 16'h0;
      repeat (2) @(negedge sys_clk_p);
      sys_reset = 1'b0;
      clear_q();
      model_tlp(1'b0, 32'h0000_A000, 10'd3, 8'h33, 32'h7777_7777);
      start_tlp(1'b0, 32'h0000_A000, 10'd3, 8'h33, 32'h7777_7777);
      @(negedge sys_clk_p);
      n_cmp++;
      if (m_axis_rx_tvalid !== 1'b1 || m_axis_rx_tdata !== 32'h4000_0003) begin
         n_err++; $display("FAIL rstmid_first_dw0 got v=%b d=%h want v=1 d=40000003", m_axis_rx_tvalid, m_axis_rx_tdata);
      end
      run_until_done(0, 50, ok, dc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_done_timeout got none want o_done"); end
      n_cmp++;
      if (got_data.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_nbeats got %0d want %0d", got_data.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
         n_cmp++;
         if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i]) begin
            n_err++; $display("FAIL rstmid_beat[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], exp_last_q[i]);
         end
      end
      exp_count++;
      n_cmp++; if (o_tlp_count !== exp_count) begin n_err++; $display("FAIL rstmid_count_after got %0d want %0d", o_tlp_count, exp_count); end
   endtask

   task automatic test_back_to_back();
      bit ok; int dc; int w; int low;
      clear_q();
      m_axis_rx_tready = 1'b1; rx_np_ok = 1'b1;
      model_tlp(1'b0, 32'h0000_B000, 10'd2, 8'h44, 32'h0000_0100);
      model_tlp(1'b1, 32'h0000_C00C, 10'd3, 8'h55, 32'h0);
      w = 0;
      @(negedge sys_clk_p);
      while (o_busy !== 1'b0 && w < 50) begin
         @(negedge sys_clk_p);
         w++;
      end
      @(posedge sys_clk_p); #1;
      i_start = 1'b1; i_is_read = 1'b0; i_addr = 32'h0000_B000; i_len = 10'd2; i_tag = 8'h44; i_data_seed = 32'h0000_0100;
      @(posedge sys_clk_p); #1;
      i_is_read = 1'b1; i_addr = 32'h0000_C00C; i_len = 10'd3; i_tag = 8'h55; i_data_seed = $urandom;
      w = 0;
      @(negedge sys_clk_p);
      while (o_done !== 1'b1 && w < 50) begin
         @(negedge sys_clk_p);
         w++;
      end
      n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got none want o_done"); end
      low = 0;
      while (m_axis_rx_tvalid !== 1'b1 && low < 30) begin
         low++;
         @(negedge sys_clk_p);
      end
      i_start = 1'b0;
      n_cmp++; if (low != G_LEN + 1) begin n_err++; $display("FAIL b2b_idle_cycles got %0d want %0d", low, G_LEN + 1); end
      run_until_done(0, 50, ok, dc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_done_timeout got none want o_done"); end
      n_cmp++;
      if (got_data.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_nbeats got %0d want %0d", got_data.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
         n_cmp++;
         if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i]) begin
            n_err++; $display("FAIL b2b_beat[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], exp_last_q[i]);
         end
      end
      exp_count = exp_count + 16'd2;
      n_cmp++; if (o_tlp_count !== exp_count) begin n_err++; $display("FAIL b2b_count got %0d want %0d", o_tlp_count, exp_count); end
      n_cmp++; if (stall_err != 0 || user_err != 0) begin n_err++; $display("FAIL b2b_stream_rules got %0d/%0d violations want 0/0", stall_err, user_err); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      sys_reset = 1'b1; i_start = 1'b0; i_is_read = 1'b0; i_addr = 32'h0; i_len = 10'h0;
      i_tag = 8'h0; i_data_seed = 32'h0; m_axis_rx_tready = 1'b1; rx_np_ok = 1'b1;
      test_reset();
      test_mwr_basic();
      test_mrd_np();
      test_backpressure();
      test_len0_wrap();
      test_random();
      test_busy_start();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_cmp++; n_err++;
      $display("FAIL watchdog got no completion want finish before 500000ns");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
